// File: rtl/bus_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bus_mem_ctrl_pkg : shared types and default bus sizes for bus_mem_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bus_mem_ctrl_pkg;

    localparam int unsigned BUS_DATA_W = 32;
    localparam int unsigned BUS_ADDR_W = 32;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage : bus_mem_ctrl_pkg

`default_nettype wire

// File: rtl/bus_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// bus_mem_ctrl_if : CPU external bus port as seen by the memory responder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface bus_mem_ctrl_if
    import bus_mem_ctrl_pkg::*;
#(
    parameter int DATA_W = BUS_DATA_W,
    parameter int ADDR_W = BUS_ADDR_W
);

    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] wdata_in;
    logic              read_q;
    logic              write_q;
    logic [DATA_W-1:0] rdata_out;
    logic              read_dn;
    logic              write_dn;
    logic              bus_busy;
    logic              err;

    modport master (
        output addr_in, wdata_in, read_q, write_q,
        input  rdata_out, read_dn, write_dn, bus_busy, err
    );

    modport slave (
        input  addr_in, wdata_in, read_q, write_q,
        output rdata_out, read_dn, write_dn, bus_busy, err
    );

endinterface : bus_mem_ctrl_if

`default_nettype wire

// File: rtl/bus_mem_ctrl_mem_sp_ram.sv
// ---------------------------------------------------------------------------
// mem_sp_ram : single-port synchronous RAM, read-first, registered read
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_sp_ram #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  wire logic                  clk,
    input  wire logic                  we_i,
    input  wire logic [DEPTH_LOG2-1:0] addr_i,
    input  wire logic [DATA_W-1:0]     wdata_i,
    output logic      [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule : mem_sp_ram

`default_nettype wire

// File: rtl/bus_mem_ctrl.sv
// ---------------------------------------------------------------------------
// bus_mem_ctrl : wait-stated memory responder for the CPU external bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bus_mem_ctrl
    import bus_mem_ctrl_pkg::*;
#(
    parameter int DATA_W      = BUS_DATA_W,
    parameter int ADDR_W      = BUS_ADDR_W,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    bus_mem_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
        $error("bus_mem_ctrl: WAIT_CYCLES must be within 0..15");
    end

    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 >= ADDR_W) begin : g_bad_depth
        $error("bus_mem_ctrl: DEPTH_LOG2 must be within 1..ADDR_W-1");
    end

    state_e            state_q;
    op_e               op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              read_dn_q;
    logic              write_dn_q;
    logic              busy_q;
    logic              err_q;

    logic                  in_range;
    logic                  req_held;
    logic                  access;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [DATA_W-1:0]     ram_rdata;

    assign in_range = (addr_q[ADDR_W-1:DEPTH_LOG2] == '0);
    assign req_held = (op_q == OP_WRITE) ? bus.write_q : bus.read_q;
    assign access   = (state_q == ST_WAIT) && (cnt_q == '0);
    assign ram_we   = access && (op_q == OP_WRITE) && in_range;

    // In IDLE the RAM is addressed straight from the bus so the registered
    // read is already valid when the zero-wait access edge arrives.
    assign ram_idx = (state_q == ST_IDLE) ? bus.addr_in[DEPTH_LOG2-1:0]
                                          : addr_q[DEPTH_LOG2-1:0];

    mem_sp_ram #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_idx),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_READ;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            read_dn_q  <= 1'b0;
            write_dn_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.read_q || bus.write_q) begin
                        addr_q  <= bus.addr_in;
                        wdata_q <= bus.wdata_in;
                        op_q    <= bus.write_q ? OP_WRITE : OP_READ;
                        cnt_q   <= WAIT_LOAD;
                        busy_q  <= 1'b1;
                        err_q   <= bus.read_q && bus.write_q;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (op_q == OP_READ) begin
                            rdata_q <= in_range ? ram_rdata : '0;
                        end
                        // Out-of-range and abort share this edge: one pulse.
                        err_q <= !in_range || !req_held;
                        if (req_held) begin
                            read_dn_q  <= (op_q == OP_READ);
                            write_dn_q <= (op_q == OP_WRITE);
                            state_q    <= ST_ACK;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_ACK: begin
                    if (!req_held) begin
                        read_dn_q  <= 1'b0;
                        write_dn_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rdata_out = rdata_q;
    assign bus.read_dn   = read_dn_q;
    assign bus.write_dn  = write_dn_q;
    assign bus.bus_busy  = busy_q;
    assign bus.err       = err_q;

endmodule : bus_mem_ctrl

`default_nettype wire
